pool_win_ctrl: RTL and testbench

Parametrised control FSM for the pooling stage of the AXI-Stream CNN pipeline. It counts an incoming pixel stream over channel, column and row using internal counters instead of externally supplied phase flags. It generates line-buffer and accumulator strobes for the pooling datapath and issues one result-valid per pooled output, with downstream back-pressure. Rows and columns beyond the last full window are discarded. The block sits between the upstream conv/activation stream and the pooling datapath.

---
 rtl/pool_pkg.sv | 25 ++
 rtl/pool_idx_cnt.sv | 70 +++++++
 rtl/pool_win_ctrl.sv | 124 ++++++++++++
 tb/tb_pool_win_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the pooling window controller.
package pool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_CALC = 3'd2,
    ST_SKIP = 3'd3,
    ST_DONE = 3'd4
  } pool_state_e;

  // Counter width that still holds values 0..n-1, never narrower than 1 bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int out_dim(input int n, input int pool);
    return n / pool;
  endfunction

  function automatic int addr_w(input int img_w, input int pool, input int ch);
    return cw(out_dim(img_w, pool) * ch);
  endfunction

endpackage

// File: rtl/pool_idx_cnt.sv
// Cascaded ch/col/row pixel counter with window-phase and window-column indices.
module pool_idx_cnt import pool_pkg::*; #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24,
  parameter int CH    = 1,
  parameter int POOL  = 2
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              adv,
  output logic [cw(CH)-1:0]                 ch,
  output logic [cw(IMG_W)-1:0]              col,
  output logic [cw(IMG_H)-1:0]              row,
  output logic [cw(POOL)-1:0]               col_ph,
  output logic [cw(POOL)-1:0]               row_ph,
  output logic [cw(IMG_W/POOL+1)-1:0]       col_win,
  output logic                              ch_wrap,
  output logic                              col_wrap,
  output logic                              row_wrap
);

  localparam int CH_W  = cw(CH);
  localparam int COL_W = cw(IMG_W);
  localparam int ROW_W = cw(IMG_H);
  localparam int PH_W  = cw(POOL);
  localparam int WIN_W = cw(IMG_W/POOL+1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(POOL-1);

  assign ch_wrap  = (ch  == CH_W'(CH-1));
  assign col_wrap = (col == COL_W'(IMG_W-1));
  assign row_wrap = (row == ROW_W'(IMG_H-1));

  // Phases are kept as their own modulo counters so no divider is needed.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      ch      <= '0;
      col     <= '0;
      row     <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
      col_win <= '0;
    end else if (adv) begin
      if (ch_wrap) ch <= '0;
      else         ch <= ch + CH_W'(1);
      if (ch_wrap) begin
        if (col_wrap) begin
          col     <= '0;
          col_ph  <= '0;
          col_win <= '0;
          if (row_wrap) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row    <= row + ROW_W'(1);
            row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + PH_W'(1);
          end
        end else begin
          col <= col + COL_W'(1);
          if (col_ph == PH_LAST) begin
            col_ph  <= '0;
            col_win <= col_win + WIN_W'(1);
          end else begin
            col_ph  <= col_ph + PH_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pool_win_ctrl.sv
// Pooling-stage control: counts the pixel stream, drives line-buffer/accumulator
// strobes and hands one pooled result per window to a back-pressured output.
module pool_win_ctrl import pool_pkg::*; #(
  parameter  int IMG_W = 24,
  parameter  int IMG_H = 24,
  parameter  int CH    = 1,
  parameter  int POOL  = 2,
  localparam int AW    = addr_w(IMG_W, POOL, CH)
) (
  input  logic          S_AXIS_ACLK,
  input  logic          S_AXIS_ARESETN,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_last,
  input  logic          m_ready,
  output logic          cal_valid,
  output logic          m_last,
  output logic          acc_init,
  output logic          line_wr,
  output logic [AW-1:0] buf_addr,
  output logic          frame_done,
  output logic          err_last
);

  localparam int OUT_W = out_dim(IMG_W, POOL);
  localparam int OUT_H = out_dim(IMG_H, POOL);
  localparam int CH_W  = cw(CH);
  localparam int COL_W = cw(IMG_W);
  localparam int ROW_W = cw(IMG_H);
  localparam int PH_W  = cw(POOL);
  localparam int WIN_W = cw(IMG_W/POOL+1);
  localparam logic [31:0]     COL_LIM  = 32'(OUT_W*POOL);
  localparam logic [31:0]     ROW_LIM  = 32'(OUT_H*POOL);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(POOL-1);
  localparam logic [PH_W-1:0] PH_PRE   = PH_W'(POOL-2);
  localparam bit              ROW_TAIL = (OUT_H*POOL < IMG_H);

  pool_state_e      state;
  logic             eof_wait;
  logic [CH_W-1:0]  ch;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PH_W-1:0]  col_ph, row_ph;
  logic [WIN_W-1:0] col_win;
  logic             ch_wrap, col_wrap, row_wrap;
  logic             xfer, pix_ok, res_gen, last_out;
  logic             row_end, frame_last, frame_end;

  pool_idx_cnt #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .POOL(POOL)
  ) u_cnt (
    .S_AXIS_ACLK    (S_AXIS_ACLK),
    .S_AXIS_ARESETN (S_AXIS_ARESETN),
    .adv            (xfer),
    .ch             (ch),
    .col            (col),
    .row            (row),
    .col_ph         (col_ph),
    .row_ph         (row_ph),
    .col_win        (col_win),
    .ch_wrap        (ch_wrap),
    .col_wrap       (col_wrap),
    .row_wrap       (row_wrap)
  );

  // Input also halts while the frame's final result is still waiting for its handshake,
  // so the next frame's first pixel cannot slip in ahead of DONE.
  assign s_ready = (state != ST_DONE) && !eof_wait && !(cal_valid && !m_ready);
  assign xfer    = s_valid && s_ready;

  assign pix_ok     = xfer && (32'(col) < COL_LIM) && (32'(row) < ROW_LIM);
  assign row_end    = xfer && ch_wrap && col_wrap;
  assign frame_last = ch_wrap && col_wrap && row_wrap;
  assign frame_end  = xfer && frame_last;

  assign acc_init = pix_ok && (row_ph == '0) && (col_ph == '0);
  assign line_wr  = pix_ok && (row_ph != PH_LAST) && (col_ph == PH_LAST);
  assign res_gen  = pix_ok && (state == ST_CALC) && (col_ph == PH_LAST);
  assign last_out = (32'(col) == COL_LIM - 32'd1) && (32'(row) == ROW_LIM - 32'd1) && ch_wrap;
  assign buf_addr = pix_ok ? AW'(32'(col_win) * 32'(CH) + 32'(ch)) : '0;

  assign frame_done = (state == ST_DONE);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state     <= ST_IDLE;
      eof_wait  <= 1'b0;
      cal_valid <= 1'b0;
      m_last    <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      if (res_gen) begin
        cal_valid <= 1'b1;
        m_last    <= last_out;
      end else if (m_ready) begin
        cal_valid <= 1'b0;
        m_last    <= 1'b0;
      end

      if (xfer && (s_last != frame_last)) err_last <= 1'b1;

      case (state)
        ST_IDLE: if (xfer) state <= ST_FILL;
        ST_FILL: if (row_end && (row_ph == PH_PRE)) state <= ST_CALC;
        ST_CALC: if (row_end)
                   state <= (ROW_TAIL && (32'(row) == ROW_LIM - 32'd1)) ? ST_SKIP : ST_FILL;
        ST_SKIP: ;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Frame end wins over the row-driven moves above.
      if (frame_end) begin
        if (res_gen) eof_wait <= 1'b1;
        else         state    <= ST_DONE;
      end
      if (eof_wait && cal_valid && m_ready) begin
        eof_wait <= 1'b0;
        state    <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_pool_win_ctrl.sv
// Scoreboard bench: three controller configurations, one shared cycle-stepped monitor.
module tb_pool_win_ctrl;

  localparam int P = 2;

  typedef struct {
    int xidx;
    bit last;
    bit eof;
  } res_t;

  logic       aclk;
  logic       rst_n;
  logic [2:0] sv, sl, mr;
  wire  [2:0] sr, cv, ml, ai, lw, fd, el;
  wire  [0:0] ba0, ba1;
  wire  [2:0] ba2;

  int checks = 0;
  int errs   = 0;

  res_t q [3][$];
  int   fidx[3], gidx[3], prev_x[3], nres[3];
  int   tx_left[3], tx_i[3], tx_last[3];
  bit   stall_prev[3], cur_eof[3], fd_exp[3];

  pool_win_ctrl #(.IMG_W(4), .IMG_H(4), .CH(1), .POOL(2)) u_dut0 (
    .S_AXIS_ACLK(aclk), .S_AXIS_ARESETN(rst_n), .s_valid(sv[0]), .s_ready(sr[0]),
    .s_last(sl[0]), .m_ready(mr[0]), .cal_valid(cv[0]), .m_last(ml[0]),
    .acc_init(ai[0]), .line_wr(lw[0]), .buf_addr(ba0), .frame_done(fd[0]), .err_last(el[0]));

  pool_win_ctrl #(.IMG_W(5), .IMG_H(5), .CH(1), .POOL(2)) u_dut1 (
    .S_AXIS_ACLK(aclk), .S_AXIS_ARESETN(rst_n), .s_valid(sv[1]), .s_ready(sr[1]),
    .s_last(sl[1]), .m_ready(mr[1]), .cal_valid(cv[1]), .m_last(ml[1]),
    .acc_init(ai[1]), .line_wr(lw[1]), .buf_addr(ba1), .frame_done(fd[1]), .err_last(el[1]));

  pool_win_ctrl #(.IMG_W(4), .IMG_H(4), .CH(3), .POOL(2)) u_dut2 (
    .S_AXIS_ACLK(aclk), .S_AXIS_ARESETN(rst_n), .s_valid(sv[2]), .s_ready(sr[2]),
    .s_last(sl[2]), .m_ready(mr[2]), .cal_valid(cv[2]), .m_last(ml[2]),
    .acc_init(ai[2]), .line_wr(lw[2]), .buf_addr(ba2), .frame_done(fd[2]), .err_last(el[2]));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic int img_w(input int d);
    return (d == 1) ? 5 : 4;
  endfunction

  function automatic int nch(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic int ba_of(input int d);
    case (d)
      0:       return int'(ba0);
      1:       return int'(ba1);
      default: return int'(ba2);
    endcase
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Reference model: walks each frame in ch/col/row order and predicts strobes and results.
  task automatic mon();
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        q[d].delete();
        fidx[d] = 0; prev_x[d] = -1;
        stall_prev[d] = 0; cur_eof[d] = 0; fd_exp[d] = 0;
      end else begin
        int w, c, n, ch, col, row;
        bit skp, fin, res, lst;
        res_t e;
        if (fd[d] || fd_exp[d]) chk("frame_done", fd[d], fd_exp[d]);
        fd_exp[d] = 0;
        if (cv[d] && !stall_prev[d]) begin
          if (q[d].size() == 0) chk("res_spurious", 1, 0);
          else begin
            e = q[d].pop_front();
            chk("res_src_xfer", prev_x[d], e.xidx);
            chk("m_last", ml[d], e.last);
            cur_eof[d] = e.eof;
            nres[d]++;
          end
        end
        if (cv[d] && mr[d] && cur_eof[d]) begin
          fd_exp[d] = 1;
          cur_eof[d] = 0;
        end
        if (cv[d] && !mr[d]) chk("s_ready_stall", sr[d], 0);
        stall_prev[d] = cv[d] && !mr[d];
        if (sv[d] && sr[d]) begin
          w = img_w(d); c = nch(d); n = w * w * c;
          ch  = fidx[d] % c;
          col = (fidx[d] / c) % w;
          row = fidx[d] / (c * w);
          skp = (col >= (w/P)*P) || (row >= (w/P)*P);
          fin = (fidx[d] == n - 1);
          res = !skp && (row % P == P-1) && (col % P == P-1);
          lst = (col == (w/P)*P - 1) && (row == (w/P)*P - 1) && (ch == c - 1);
          chk("acc_init", ai[d], !skp && (row % P == 0) && (col % P == 0));
          chk("line_wr", lw[d], !skp && (row % P != P-1) && (col % P == P-1));
          if (!skp) chk("buf_addr", ba_of(d), (col / P) * c + ch);
          if (res) q[d].push_back('{gidx[d], lst, fin});
          if (fin && !res) fd_exp[d] = 1;
          prev_x[d] = gidx[d];
          gidx[d]++;
          fidx[d] = fin ? 0 : fidx[d] + 1;
          tx_left[d]--;
          tx_i[d]++;
        end else begin
          prev_x[d] = -1;
          chk("strobe_idle", int'(ai[d] | lw[d]), 0);
        end
      end
    end
  endtask

  task automatic cyc();
    for (int d = 0; d < 3; d++) begin
      sv[d] = (tx_left[d] > 0);
      sl[d] = (tx_left[d] > 0) && (tx_i[d] == tx_last[d]);
    end
    @(negedge aclk);
    mon();
    @(posedge aclk);
    #1;
  endtask

  task automatic start(input int d, input int n, input int last_at);
    tx_left[d] = n; tx_i[d] = 0; tx_last[d] = last_at;
  endtask

  task automatic finish_tx(input int d);
    for (int t = 0; t < 400 && tx_left[d] > 0; t++) cyc();
    if (tx_left[d] != 0) begin
      chk("xfer_timeout", tx_left[d], 0);
      tx_left[d] = 0;
    end
  endtask

  task automatic frame(input int d, input int n, input int last_at, input int exp_res);
    int r0;
    r0 = nres[d];
    start(d, n, last_at);
    finish_tx(d);
    repeat (5) cyc();
    chk("pending_res", q[d].size(), 0);
    chk("n_results", nres[d] - r0, exp_res);
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, int'({cv, ml, fd, el, ai, lw}), 0);
    chk({tag, "_s_ready"}, int'(sr), 7);
    chk({tag, "_buf_addr"}, ba_of(0) + ba_of(1) + ba_of(2), 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; sv = '0; sl = '0; mr = 3'b111;
    for (int d = 0; d < 3; d++) begin
      tx_left[d] = 0; tx_i[d] = 0; tx_last[d] = -1; gidx[d] = 0; nres[d] = 0;
    end
    repeat (3) cyc();
    idle_chk("reset");
    rst_n = 1'b1;
    repeat (2) cyc();
    idle_chk("post_reset");

    // 4x4, continuous, then again with a 3-cycle stall at the first result.
    frame(0, 16, 15, 4);
    chk("err_last_clean", el[0], 0);

    start(0, 16, 15);
    t = 0;
    while (!cv[0] && t < 50) begin cyc(); t++; end
    chk("stall_seen_result", cv[0], 1);
    mr[0] = 1'b0;
    repeat (3) cyc();
    mr[0] = 1'b1;
    finish_tx(0);
    repeat (5) cyc();
    chk("stall_pending_res", q[0].size(), 0);

    // 5x5 with skipped tail column/row, then 3-channel 4x4.
    frame(1, 25, 24, 4);
    chk("err_last_5x5", el[1], 0);
    frame(2, 48, 47, 12);
    chk("err_last_ch3", el[2], 0);

    // Early s_last: sticky error, frame still completes on the counters.
    frame(0, 16, 10, 4);
    chk("err_last_set", el[0], 1);
    repeat (5) cyc();
    chk("err_last_sticky", el[0], 1);

    // Reset while a result is stalled.
    mr[0] = 1'b0;
    start(0, 6, -1);
    finish_tx(0);
    repeat (2) cyc();
    chk("pre_rst_cal_valid", cv[0], 1);
    chk("pre_rst_s_ready", sr[0], 0);
    rst_n = 1'b0;
    #1;
    chk("rst_cal_valid", cv[0], 0);
    chk("rst_s_ready", sr[0], 1);
    chk("rst_err_last", el[0], 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    mr[0] = 1'b1;
    frame(0, 16, 15, 4);
    chk("err_last_after_rst", el[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
